// File: rtl/bram_rr_arbiter_pkg.sv
// Shared definitions for the two-port round-robin BRAM arbiter.
//   - port_idx_t : index of a requester port (also used as the priority value)
//   - field_lsb  : LSB offset of a port's field inside a packed per-port bus
//   - sat_inc    : increment that sticks at all-ones for a given counter width
package bram_rr_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_t;

  // Packed per-port buses carry port 0 in the LSBs.
  function automatic int unsigned field_lsb(input port_idx_t port, input int unsigned field_w);
    if (port == PORT1) begin
      return field_w;
    end else begin
      return 32'd0;
    end
  endfunction

  // Increment val, saturating at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32'd32 - width);
    if (val >= max_v) begin
      return max_v;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter core.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i[1:0]   : per-port request (valid)
//   gnt_o[1:0]   : one-hot (or zero) grant, combinational
// The priority flop names the port favoured when both request; after a grant
// it points at the other port, so continuous dual requests alternate.
module bram_rr_arbiter_rr_arb2
  import bram_rr_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_idx_t prio_q;
  port_idx_t prio_d;
  logic [1:0] gnt_s;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    gnt_s = 2'b00;
    if (rst_i) begin
      gnt_s = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (prio_q == PORT1) ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Next priority: favour the port that was not just served.
  always_comb begin
    prio_d = prio_q;
    if (gnt_s[0]) begin
      prio_d = PORT1;
    end else if (gnt_s[1]) begin
      prio_d = PORT0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= PORT0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_o = gnt_s;

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   req_valid_i/_we_i : per-port request valid / write enable
//   req_addr_i        : packed per-port addresses (port 0 in LSBs)
//   req_wdata_i       : packed per-port write data (port 0 in LSBs)
//   req_ready_o       : per-port grant (combinational, at most one bit set)
//   rsp_valid_o       : one-cycle response pulse, cycle after acceptance
//   rsp_err_o         : response qualifier, address was out of range
//   rsp_rdata_o       : response data (word read in the accept cycle, 0 on error)
//   mem_we_o/_addr_o/_din_o, mem_dout_i : memory port (combinational read)
//   acc_cnt_o         : packed per-port saturating accept counters
module bram_rr_arbiter
  import bram_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1600,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [NUM_PORTS-1:0]            rsp_err_o,
  output logic [WIDTH-1:0]                rsp_rdata_o,
  output logic                            mem_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [WIDTH-1:0]                mem_din_o,
  input  logic [WIDTH-1:0]                mem_dout_i,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  acc_cnt_o
);

  localparam int unsigned ADDR_LSB0 = field_lsb(PORT0, ADDR_WIDTH);
  localparam int unsigned ADDR_LSB1 = field_lsb(PORT1, ADDR_WIDTH);
  localparam int unsigned DATA_LSB0 = field_lsb(PORT0, WIDTH);
  localparam int unsigned DATA_LSB1 = field_lsb(PORT1, WIDTH);

  logic [1:0]            gnt_s;
  logic                  grant_any_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WIDTH-1:0]      sel_wdata_s;
  logic                  sel_we_s;
  logic                  in_range_s;

  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [CNT_WIDTH-1:0]  acc_cnt0_q, acc_cnt0_d;
  logic [CNT_WIDTH-1:0]  acc_cnt1_q, acc_cnt1_d;

  bram_rr_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .gnt_o (gnt_s)
  );

  // Steer the granted port onto the memory bus; port 0 drives it when idle.
  always_comb begin
    grant_any_s = |gnt_s;
    sel_addr_s  = req_addr_i[ADDR_LSB0 +: ADDR_WIDTH];
    sel_wdata_s = req_wdata_i[DATA_LSB0 +: WIDTH];
    sel_we_s    = req_we_i[0];
    if (gnt_s[1]) begin
      sel_addr_s  = req_addr_i[ADDR_LSB1 +: ADDR_WIDTH];
      sel_wdata_s = req_wdata_i[DATA_LSB1 +: WIDTH];
      sel_we_s    = req_we_i[1];
    end else begin
      sel_addr_s  = req_addr_i[ADDR_LSB0 +: ADDR_WIDTH];
      sel_wdata_s = req_wdata_i[DATA_LSB0 +: WIDTH];
      sel_we_s    = req_we_i[0];
    end
    in_range_s = (sel_addr_s < ADDR_WIDTH'(DEPTH));
    // gnt_s is already zero during reset, so no write can slip through.
    mem_we_o   = grant_any_s & sel_we_s & in_range_s;
    mem_addr_o = sel_addr_s;
    mem_din_o  = sel_wdata_s;
  end

  // Response and counter next-state; read data is captured before any write lands.
  always_comb begin
    rsp_valid_d = gnt_s;
    rsp_err_d   = in_range_s ? 2'b00 : gnt_s;
    rsp_rdata_d = {WIDTH{1'b0}};
    if (grant_any_s & in_range_s) begin
      rsp_rdata_d = mem_dout_i;
    end else begin
      rsp_rdata_d = {WIDTH{1'b0}};
    end
    if (gnt_s[0]) begin
      acc_cnt0_d = CNT_WIDTH'(sat_inc(32'(acc_cnt0_q), CNT_WIDTH));
    end else begin
      acc_cnt0_d = acc_cnt0_q;
    end
    if (gnt_s[1]) begin
      acc_cnt1_d = CNT_WIDTH'(sat_inc(32'(acc_cnt1_q), CNT_WIDTH));
    end else begin
      acc_cnt1_d = acc_cnt1_q;
    end
  end

  // Response and counter registers; reset drops any pending response at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_rdata_q <= {WIDTH{1'b0}};
      acc_cnt0_q  <= {CNT_WIDTH{1'b0}};
      acc_cnt1_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      acc_cnt0_q  <= acc_cnt0_d;
      acc_cnt1_q  <= acc_cnt1_d;
    end
  end

  assign req_ready_o = gnt_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign acc_cnt_o   = {acc_cnt1_q, acc_cnt0_q};

endmodule
